// File: rtl/num_ram_access_ctrl_if.sv
// Request/response bundle between the number-RAM access controller and its clients:
// one writer (the separator) and two read clients.
interface num_ram_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) ();
  logic                  w_valid;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_ready;

  logic                  r0_valid;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic                  r0_ready;
  logic                  r0_rvalid;
  logic [DATA_WIDTH-1:0] r0_rdata;

  logic                  r1_valid;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic                  r1_ready;
  logic                  r1_rvalid;
  logic [DATA_WIDTH-1:0] r1_rdata;

  modport master (
    output w_valid, w_addr, w_data, r0_valid, r0_addr, r1_valid, r1_addr,
    input  w_ready, r0_ready, r0_rvalid, r0_rdata, r1_ready, r1_rvalid, r1_rdata
  );

  modport slave (
    input  w_valid, w_addr, w_data, r0_valid, r0_addr, r1_valid, r1_addr,
    output w_ready, r0_ready, r0_rvalid, r0_rdata, r1_ready, r1_rvalid, r1_rdata
  );
endinterface

// File: rtl/num_ram_access_ctrl.sv
// Access controller for the number RAM: shares the write port and arbitrates the read port,
// sequences clears. Optional read-after-write bypass: define NUM_RAM_RAW_BYPASS_EN.
module num_ram_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  num_ram_access_ctrl_if.slave  bus,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  addr_err,
  output logic                  ram_clear,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  dbg_state
);

  // Handshake: a request is taken in every cycle where its valid and ready are both high.
  // Ready is combinational (read readies also depend on the other client's valid), and each
  // granted read returns a one-cycle rvalid pulse exactly one cycle later.

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
  logic                  accept;
  logic                  rr_ptr;
  logic                  gnt0, gnt1;
  logic                  w_in_range, rd_oor;
  logic [ADDR_WIDTH-1:0] sel_addr, rd_addr_q;
  logic                  rv0_q, rv1_q, oor_q;
  logic [DATA_WIDTH-1:0] hold0_q, hold1_q;
  logic [DATA_WIDTH-1:0] rd_ram, rd_src;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_clear = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          ram_clear = 1'b1;
          cnt_nxt   = DEPTH_W;
          state_nxt = S_CLEAR;
        end else begin
          accept = 1'b1;
        end
      end
      S_CLEAR: begin
        // Stays here DEPTH cycles, matching the RAM's own clear walk.
        cnt_nxt = cnt - ONE_W;
        if (cnt == ONE_W) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign clear_busy = (state == S_CLEAR);
  assign dbg_state  = state;

  assign w_in_range  = {1'b0, bus.w_addr} < DEPTH_W;
  assign bus.w_ready = accept;
  assign ram_wr_en   = accept && bus.w_valid && w_in_range;
  assign ram_wr_addr = bus.w_addr;
  assign ram_wr_data = bus.w_data;

  // rr_ptr names the client that wins when both request.
  assign gnt0 = accept && bus.r0_valid && (!bus.r1_valid || !rr_ptr);
  assign gnt1 = accept && bus.r1_valid && (!bus.r0_valid ||  rr_ptr);
  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;

  assign sel_addr    = gnt0 ? bus.r0_addr : bus.r1_addr;
  assign rd_oor      = {1'b0, sel_addr} >= DEPTH_W;
  assign ram_rd_addr = (gnt0 || gnt1) ? sel_addr : rd_addr_q;

`ifdef NUM_RAM_RAW_BYPASS_EN
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= ram_wr_en && (gnt0 || gnt1) && (sel_addr == bus.w_addr);
      byp_data_q <= bus.w_data;
    end
  end

  assign rd_ram = byp_q ? byp_data_q : ram_rd_data;
`else
  assign rd_ram = ram_rd_data;
`endif

  assign rd_src = oor_q ? '0 : rd_ram;

  assign bus.r0_rvalid = rv0_q;
  assign bus.r1_rvalid = rv1_q;
  assign bus.r0_rdata  = rv0_q ? rd_src : hold0_q;
  assign bus.r1_rdata  = rv1_q ? rd_src : hold1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rr_ptr    <= 1'b0;
      wr_count  <= '0;
      addr_err  <= 1'b0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      oor_q     <= 1'b0;
      rd_addr_q <= '0;
      hold0_q   <= '0;
      hold1_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rv0_q    <= gnt0;
      rv1_q    <= gnt1;
      oor_q    <= (gnt0 || gnt1) && rd_oor;
      addr_err <= (accept && bus.w_valid && !w_in_range) || ((gnt0 || gnt1) && rd_oor);
      if (gnt0 || gnt1) begin
        rr_ptr    <= gnt0;
        rd_addr_q <= sel_addr;
      end
      if (ram_clear)
        wr_count <= '0;
      else if (ram_wr_en && (wr_count != DEPTH_W))
        wr_count <= wr_count + ONE_W;
      if (rv0_q) hold0_q <= rd_src;
      if (rv1_q) hold1_q <= rd_src;
    end
  end

endmodule

// File: tb/tb_num_ram_access_ctrl.sv
// Bench for num_ram_access_ctrl: directed steps plus random traffic against a memory-level
// reference model, with a behavioural registered-read RAM attached to the RAM ports.
module tb_num_ram_access_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 1000;
`ifdef NUM_RAM_RAW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk, rst, clear_req;
  logic          clear_busy, addr_err, ram_clear, ram_wr_en, dbg_state;
  logic [AW:0]   wr_count;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  num_ram_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  num_ram_access_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clear_req(clear_req), .clear_busy(clear_busy),
    .wr_count(wr_count), .addr_err(addr_err), .ram_clear(ram_clear), .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural RAM: registered read, read-before-write, contents zeroed by clear or reset
  logic [DW-1:0] ram_mem [2**AW];
  always @(posedge clk) begin
    if (rst || ram_clear) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
    end else if (ram_wr_en) begin
      ram_mem[ram_wr_addr] <= ram_wr_data;
    end
    if (rst) ram_rd_data <= '0;
    else     ram_rd_data <= (int'(ram_rd_addr) < DEPTH) ? ram_mem[ram_rd_addr] : 32'hDEAD_BEEF;
  end

  // reference model and scoreboard
  logic [DW-1:0] mem_m [2**AW];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] last0, last1;
  logic [AW-1:0] last_a;
  logic          m_rr;
  int            m_cnt;
  int            n_pass, n_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
    exp_q0.delete();
    exp_q1.delete();
    last0 = '0; last1 = '0; last_a = '0; m_rr = 1'b0; m_cnt = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(DEPTH, 2**AW - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic drive_cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic v0, input logic [AW-1:0] a0,
                             input logic v1, input logic [AW-1:0] a1);
    logic          g0, g1, we, err;
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    clear_req = 1'b0;
    bus.w_valid = wv;  bus.w_addr = wa;  bus.w_data = wd;
    bus.r0_valid = v0; bus.r0_addr = a0;
    bus.r1_valid = v1; bus.r1_addr = a1;
    #1;
    g0 = v0 && (!v1 || !m_rr);
    g1 = v1 && (!v0 || m_rr);
    we = wv && (int'(wa) < DEPTH);
    a  = g0 ? a0 : a1;
    check("ready", 64'({bus.w_ready, bus.r0_ready, bus.r1_ready}), 64'({1'b1, g0, g1}));
    check("ram_wr_en", 64'(ram_wr_en), 64'(we));
    if (g0 || g1) begin
      check("ram_rd_addr", 64'(ram_rd_addr), 64'(a));
      if (int'(a) >= DEPTH)     rd = '0;
      else if (BYP && we && wa == a) rd = wd;
      else                      rd = mem_m[a];
      if (g0) exp_q0.push_back(rd);
      else    exp_q1.push_back(rd);
      last_a = a;
    end else begin
      check("ram_rd_addr_hold", 64'(ram_rd_addr), 64'(last_a));
    end
    err = (wv && int'(wa) >= DEPTH) || ((g0 || g1) && int'(a) >= DEPTH);
    if (we) begin
      mem_m[wa] = wd;
      if (m_cnt < DEPTH) m_cnt++;
    end
    if (g0 || g1) m_rr = g0;
    @(posedge clk); #1;
    check("rvalid", 64'({bus.r0_rvalid, bus.r1_rvalid}), 64'({g0, g1}));
    if (g0 && exp_q0.size() > 0) last0 = exp_q0.pop_front();
    if (g1 && exp_q1.size() > 0) last1 = exp_q1.pop_front();
    check("r0_rdata", 64'(bus.r0_rdata), 64'(last0));
    check("r1_rdata", 64'(bus.r1_rdata), 64'(last1));
    check("addr_err", 64'(addr_err), 64'(err));
    check("wr_count", 64'(wr_count), 64'(m_cnt));
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(1'($urandom_range(0, 1)), rand_addr(), DW'($urandom),
                  1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), rand_addr());
  endtask

  task automatic do_clear(input logic wv);
    int n, bad;
    clear_req = 1'b1;
    bus.w_valid = wv; bus.w_addr = AW'(3); bus.w_data = DW'($urandom);
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
    #1;
    check("clr_ram_clear", 64'(ram_clear), 64'(1));
    check("clr_ready", 64'({bus.w_ready, bus.r0_ready, bus.r1_ready}), 64'(0));
    check("clr_wr_en", 64'(ram_wr_en), 64'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
    m_cnt = 0;
    check("clr_busy", 64'(clear_busy), 64'(1));
    check("clr_wr_count", 64'(wr_count), 64'(0));
    check("clr_rvalid", 64'({bus.r0_rvalid, bus.r1_rvalid}), 64'(0));
    n = 0; bad = 0;
    while (clear_busy === 1'b1 && n < 2 * DEPTH) begin
      clear_req    = (n == DEPTH / 2);
      bus.w_valid  = 1'($urandom_range(0, 1)); bus.w_addr = rand_addr(); bus.w_data = DW'($urandom);
      bus.r0_valid = 1'($urandom_range(0, 1)); bus.r0_addr = rand_addr();
      bus.r1_valid = 1'($urandom_range(0, 1)); bus.r1_addr = rand_addr();
      #1;
      if (bus.w_ready || bus.r0_ready || bus.r1_ready || ram_wr_en || ram_clear) bad++;
      @(posedge clk); #1;
      if (bus.r0_rvalid || bus.r1_rvalid || addr_err) bad++;
      n++;
    end
    clear_req = 1'b0;
    check("clr_blocked", 64'(bad), 64'(0));
    check("clr_length", 64'(n), 64'(DEPTH));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    clear_req = 1'b0;
    bus.w_valid = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    bus.r0_valid = 1'b0; bus.r0_addr = '0; bus.r1_valid = 1'b0; bus.r1_addr = '0;
    apply_reset();
    check("rst_busy", 64'(clear_busy), 64'(0));
    check("rst_wr_count", 64'(wr_count), 64'(0));
    check("rst_addr_err", 64'(addr_err), 64'(0));
    check("rst_rvalid", 64'({bus.r0_rvalid, bus.r1_rvalid}), 64'(0));
    check("rst_rdata", 64'({bus.r0_rdata, bus.r1_rdata}), 64'(0));
    check("rst_ram_clear", 64'(ram_clear), 64'(0));

    // write then read back through client 0
    drive_cycle(1'b1, AW'(5), 32'h0000_002A, 1'b0, '0, 1'b0, '0);
    drive_cycle(1'b0, '0, '0, 1'b1, AW'(5), 1'b0, '0);
    check("t1_rdata", 64'(bus.r0_rdata), 64'(32'h2A));
    check("t1_wr_count", 64'(wr_count), 64'(1));

    // alternating grants with both clients requesting every cycle
    drive_cycle(1'b1, AW'(1), 32'hA1, 1'b0, '0, 1'b0, '0);
    drive_cycle(1'b1, AW'(2), 32'hB2, 1'b0, '0, 1'b1, AW'(2));
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1, AW'(1), 1'b1, AW'(2));
      check("alt_order", 64'({bus.r0_rvalid, bus.r1_rvalid}), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      check("alt_data", 64'((i % 2 == 0) ? bus.r0_rdata : bus.r1_rdata),
            (i % 2 == 0) ? 64'(32'hA1) : 64'(32'hB2));
    end

    // out-of-range write and read
    drive_cycle(1'b1, AW'(1500), 32'h77, 1'b0, '0, 1'b0, '0);
    check("oor_w_err", 64'(addr_err), 64'(1));
    drive_cycle(1'b0, '0, '0, 1'b1, AW'(1500), 1'b0, '0);
    check("oor_r_data", 64'(bus.r0_rdata), 64'(0));

    // same-cycle write and read of one address
    drive_cycle(1'b1, AW'(7), 32'h11, 1'b0, '0, 1'b0, '0);
    drive_cycle(1'b1, AW'(7), 32'h55, 1'b0, '0, 1'b1, AW'(7));
    check("raw_data", 64'(bus.r1_rdata), BYP ? 64'(32'h55) : 64'(32'h11));

    random_cycles(400);

    // clear with a simultaneous write, then everything reads back as zero
    do_clear(1'b1);
    drive_cycle(1'b1, AW'(9), 32'hC3, 1'b1, AW'(4), 1'b0, '0);
    check("post_clr_data", 64'(bus.r0_rdata), 64'(0));
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(i + 8));
    random_cycles(200);

    // reset in the middle of a clear
    clear_req = 1'b1;
    #1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", 64'(clear_busy), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(clear_busy), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_wr_count", 64'(wr_count), 64'(0));
    random_cycles(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/num_ram_access_ctrl.md
Name: num_ram_access_ctrl

Overview:
- Access controller for the number storage RAM (dual-port, registered read, self-sequenced clear, DEPTH-cycle clear walk).
- Shares the single RAM write port with one writer (ASCII number separator output) and the single RAM read port between two read clients.
- Sequences the clear command, blocks access while the RAM is clearing, and tracks read-return routing plus a written-entry count.
- Sits between the separator/consumers and the RAM instance.

Parameters:
DATA_WIDTH  32    RAM word width
DEPTH       2048  RAM entries; clear walk length
ADDR_WIDTH  11    address width; DEPTH <= 2**ADDR_WIDTH

Ports:
clk            in   1               clock
rst            in   1               asynchronous active-high reset
clear_req      in   1               start clear (single-cycle pulse or level; edge not required)
clear_busy     out  1               clear in progress
w_valid        in   1               write request
w_addr         in   ADDR_WIDTH      write address
w_data         in   DATA_WIDTH      write data
w_ready        out  1               write accepted this cycle (combinational)
r0_valid       in   1               client 0 read request
r0_addr        in   ADDR_WIDTH      client 0 address
r0_ready       out  1               client 0 granted (combinational)
r0_rvalid      out  1               client 0 data valid pulse
r0_rdata       out  DATA_WIDTH      client 0 read data
r1_valid, r1_addr, r1_ready, r1_rvalid, r1_rdata   same as client 0, for client 1
wr_count       out  ADDR_WIDTH+1    accepted in-range writes since last clear, saturating at DEPTH
addr_err       out  1               one-cycle pulse: accepted write or read with address >= DEPTH
ram_clear      out  1               to RAM clear
ram_wr_en      out  1               to RAM wr_en
ram_wr_addr    out  ADDR_WIDTH      to RAM wr_addr
ram_wr_data    out  DATA_WIDTH      to RAM wr_data
ram_rd_addr    out  ADDR_WIDTH      to RAM rd_addr
ram_rd_data    in   DATA_WIDTH      from RAM rd_data

Behaviour:
- Reset values: state IDLE, clear_busy 0, ram_clear 0, all rvalid 0, all rdata 0, wr_count 0, addr_err 0, RR pointer = client 0. RAM reset is tied to ~rst at top level.
- States:
  - IDLE:
    - clear_req=1 drives ram_clear=1 for exactly one cycle (combinational in this cycle), loads down-counter = DEPTH, clears wr_count, then enters CLEAR.
    - In the clear_req cycle, w_ready, r0_ready and r1_ready are all 0; clear wins over simultaneous requests.
  - CLEAR:
    - clear_busy=1; w_ready, r0_ready and r1_ready are 0; clear_req ignored.
    - Counter decrements each cycle; return to IDLE when it reaches 0, i.e. after DEPTH cycles, which matches the RAM walk.
    - First access is accepted DEPTH+1 cycles after the clear_req cycle.
- Writes (IDLE, no clear_req):
  - w_ready=1; ram_wr_en = w_valid && (w_addr < DEPTH); address and data pass through combinationally.
  - wr_count increments per accepted in-range write and saturates at DEPTH. It counts writes, not unique addresses.
  - An out-of-range write is accepted and dropped, and addr_err pulses the next cycle.
- Reads (IDLE, no clear_req):
  - At most one grant per cycle.
  - Only one client valid: that client is granted.
  - Both valid: the client the RR pointer selects is granted. The pointer moves to the other client after every grant to client 0 or 1.
  - ram_rd_addr = granted client's address (combinational mux; holds last value when no grant).
  - Granted id is registered; the cycle after the grant, rX_rvalid=1 for that client only and rX_rdata = ram_rd_data. Latency is 1 cycle. Back-to-back grants every cycle are supported.
  - An out-of-range read is granted, returns rvalid with data 0, and pulses addr_err.
  - Write and read to the same address in the same cycle return old data (read-before-write) unless bypass is compiled in.
- rdata holds its last value when rvalid=0.
- Reset mid-CLEAR: immediate IDLE, busy 0. RAM contents are undefined; the user re-clears.

Optional Feature:
- Macro: NUM_RAM_RAW_BYPASS_EN.
- Defined:
  - Same-cycle accepted in-range write and granted read to an equal address register a bypass flag and w_data.
  - The next cycle's rX_rdata returns that w_data instead of ram_rd_data.
- Undefined: old RAM data is returned; there is no bypass logic.

Test Plan:
- Write 0x0000002A @5, then r0 reads @5 -> r0_ready=1, next cycle r0_rvalid=1, r0_rdata=0x2A, r1_rvalid=0; wr_count=1.
- r0 and r1 both valid continuously, r0 @1, r1 @2, after reset -> grants alternate r0,r1,r0,r1; each rvalid is one cycle after its grant with the matching data.
- clear_req with w_valid in same cycle -> w_ready=0, ram_clear pulse, clear_busy high DEPTH cycles; every read afterwards returns 0; wr_count=0.
- Requests during CLEAR (writes and reads) -> no ready, no ram_wr_en; first acceptance exactly DEPTH+1 cycles after the clear_req cycle; a second clear_req mid-clear is ignored.
- DEPTH=1000: write @1500 -> ram_wr_en=0, addr_err pulse, wr_count unchanged; read @1500 -> rvalid with data 0.
- Same-cycle write 0x55 and r1 read @7 (old 0x11) -> returns 0x11 without the macro, 0x55 with NUM_RAM_RAW_BYPASS_EN. Also assert rst mid-clear -> clear_busy=0 immediately.
